// File: rtl/processor_mc_if.sv
// processor_mc_if: shared memory port with a req/ack handshake.
// master: core side (req, we, addr, wdata out; rdata, ack in); slave: memory.
interface processor_mc_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/processor_mc.sv
// processor_mc: multicycle core, one shared memory port for fetch and data.
// Ports: clk, reset (sync, active-high), mem (processor_mc_if.master),
//   pc_out (current PC), flags ({neg, zero}), halted (HALT state).
// Optional: define PROCESSOR_MC_MUL_EN to make opcode 11 a MUL.
module processor_mc #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  processor_mc_if.master    mem,
  output logic [ADDR_W-1:0] pc_out,
  output logic [1:0]        flags,
  output logic              halted
);
  localparam int RW = $clog2(REG_N);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_JR   = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic              req, req_nxt;
  logic [ADDR_W-1:0] pc, pc_inc, pc_nx, ea;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, res, imm, alu;
  logic [DATA_W-1:0] rf [REG_N];
  logic [3:0]        op;
  logic [RW-1:0]     rd, rs, rt;
  logic              acc, alu_op, is_ldst, is_sw;

  assign op  = ir[31:28];
  assign rd  = ir[24 +: RW];
  assign rs  = ir[20 +: RW];
  assign rt  = ir[16 +: RW];
  assign imm = {{(DATA_W-16){ir[15]}}, ir[15:0]};

  // An ack only counts against a request that is actually outstanding.
  assign acc     = req && mem.ack;
  assign is_sw   = (op == OP_SW);
  assign is_ldst = (op == OP_LW) || is_sw;
  assign ea      = a[ADDR_W-1:0] + imm[ADDR_W-1:0];
  assign pc_inc  = pc + ADDR_W'(1);

  assign mem.req   = req;
  assign mem.we    = (state == S_MEM) && is_sw;
  assign mem.addr  = (state == S_MEM) ? ea : pc;
  assign mem.wdata = b;
  assign pc_out    = pc;
  assign halted    = (state == S_HALT);

  always_comb begin
    alu    = '0;
    alu_op = 1'b0;
    unique case (op)
      OP_ADD:  begin alu = a + b;   alu_op = 1'b1; end
      OP_SUB:  begin alu = a - b;   alu_op = 1'b1; end
      OP_AND:  begin alu = a & b;   alu_op = 1'b1; end
      OP_OR:   begin alu = a | b;   alu_op = 1'b1; end
      OP_ADDI: begin alu = a + imm; alu_op = 1'b1; end
`ifdef PROCESSOR_MC_MUL_EN
      OP_MUL:  begin alu = a * b;   alu_op = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    pc_nx = pc_inc;
    unique case (op)
      OP_BEQ:  pc_nx = (a == b) ? pc_inc + imm[ADDR_W-1:0] : pc_inc;
      OP_JMP:  pc_nx = imm[ADDR_W-1:0];
      OP_JR:   pc_nx = a[ADDR_W-1:0];
      default: ;
    endcase
  end

  // req is registered; it is raised on the edge that enters FETCH/MEM
  // so a zero-wait access completes in the state's first cycle.
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    unique case (state)
      S_FETCH: begin
        if (acc) begin
          state_nxt = S_DECODE;
          req_nxt   = 1'b0;
        end else begin
          req_nxt   = 1'b1;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (alu_op) begin
          state_nxt = S_WB;
        end else if (is_ldst) begin
          state_nxt = S_MEM;
          req_nxt   = 1'b1;
        end else if (op == OP_HALT) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
          req_nxt   = 1'b1;
        end
      end
      S_MEM: begin
        if (acc) begin
          state_nxt = is_sw ? S_FETCH : S_WB;
          req_nxt   = is_sw;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        req_nxt   = 1'b1;
      end
      S_HALT: ;
      default: begin
        state_nxt = S_FETCH;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      req   <= 1'b0;
      pc    <= '0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      flags <= '0;
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      unique case (state)
        S_FETCH: if (acc) ir <= mem.rdata[31:0];
        S_DECODE: begin
          a <= (rs == '0) ? '0 : rf[rs];
          b <= (rt == '0) ? '0 : rf[rt];
        end
        S_EXEC: begin
          if (alu_op) begin
            res   <= alu;
            flags <= {alu[DATA_W-1], alu == '0};
          end
          if (state_nxt == S_FETCH) pc <= pc_nx;
        end
        S_MEM: begin
          if (acc) begin
            if (is_sw) pc  <= pc_inc;
            else       res <= mem.rdata;
          end
        end
        S_WB: begin
          if (rd != '0) rf[rd] <= res;
          pc <= pc_inc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_processor_mc.sv
// tb_processor_mc: directed programs against a wait-state memory model.
// Checks reset state, ALU/flags, load/store handshake, branches, reset abort.
module tb_processor_mc;
  logic       clk;
  logic       reset;
  logic [9:0] pc_out;
  logic [1:0] flags;
  logic       halted;

  processor_mc_if #(.DATA_W(32), .ADDR_W(10)) m ();

  processor_mc #(.DATA_W(32), .REG_N(16), .ADDR_W(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem    (m.master),
    .pc_out (pc_out),
    .flags  (flags),
    .halted (halted)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] prog [1024];
  logic [31:0] mem  [1024];
  int   ws, wcnt, grants, swc, lwc;
  logic hold, pulse, load;

  localparam logic [31:0] HALT = 32'hF000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acts on the falling edge, the core samples on the rising.
  always @(negedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) mem[i] = prog[i];
      wcnt = 0; grants = 0; swc = 0; lwc = 0;
      m.ack = 1'b0;
      m.rdata = '0;
    end else begin
      if (m.req === 1'b1 && m.addr == 10'd100) begin
        if (m.we) swc++;
        else      lwc++;
      end
      if (pulse) begin
        m.ack   = 1'b1;
        m.rdata = 32'h5700_0009;
      end else if (m.req === 1'b1 && !hold) begin
        if (wcnt == ws) begin
          m.ack   = 1'b1;
          m.rdata = mem[m.addr];
          if (m.we) mem[m.addr] = m.wdata;
          wcnt = 0;
          grants++;
        end else begin
          m.ack = 1'b0;
          wcnt++;
        end
      end else begin
        m.ack = 1'b0;
        wcnt  = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog;
    for (int i = 0; i < 1024; i++) prog[i] = '0;
  endtask

  // Holds reset over two edges while the model loads the program.
  task automatic start(input int w);
    ws = w; hold = 1'b0; pulse = 1'b0;
    reset = 1'b1;
    load = 1'b1;
    tick;
    tick;
    load = 1'b0;
  endtask

  task automatic run_to_halt(output int n);
    n = 0;
    while (!halted && n < 400) begin
      tick;
      n++;
    end
    chk("halt", {31'd0, halted}, 32'd1);
  endtask

  int n;

  initial begin
    reset = 1'b1; hold = 1'b0; pulse = 1'b0; load = 1'b0; ws = 0;

    // ADDI/ADDI/ADD/HALT, zero-wait, cycle count from reset release
    clear_prog();
    prog[0] = 32'h5100_0005;
    prog[1] = 32'h5200_FFFD;
    prog[2] = 32'h1312_0000;
    prog[3] = HALT;
    start(0);
    chk("rst_pc",    {22'd0, pc_out}, 32'd0);
    chk("rst_req",   {31'd0, m.req}, 32'd0);
    chk("rst_we",    {31'd0, m.we}, 32'd0);
    chk("rst_addr",  {22'd0, m.addr}, 32'd0);
    chk("rst_wdata", m.wdata, 32'd0);
    chk("rst_flags", {30'd0, flags}, 32'd0);
    chk("rst_halt",  {31'd0, halted}, 32'd0);
    reset = 1'b0;
    tick;
    chk("first_req", {31'd0, m.req}, 32'd1);
    run_to_halt(n);
    chk("cycles", n, 32'd15);
    chk("r1", dut.rf[1], 32'd5);
    chk("r2", dut.rf[2], 32'hFFFF_FFFD);
    chk("r3", dut.rf[3], 32'd2);
    chk("flags_add", {30'd0, flags}, 32'd0);

    // SUB giving zero
    clear_prog();
    prog[0] = 32'h5100_0005;
    prog[1] = 32'h5200_FFFD;
    prog[2] = 32'h2411_0000;
    prog[3] = HALT;
    start(0);
    reset = 1'b0;
    run_to_halt(n);
    chk("r4", dut.rf[4], 32'd0);
    chk("flags_z", {30'd0, flags}, 32'd1);

    // SUB giving a negative result
    prog[2] = 32'h2521_0000;
    start(0);
    reset = 1'b0;
    run_to_halt(n);
    chk("r5", dut.rf[5], 32'hFFFF_FFF8);
    chk("flags_n", {30'd0, flags}, 32'd2);

    // Store then load through two wait states
    clear_prog();
    prog[0] = 32'h5100_0005;
    prog[1] = 32'h7001_0064;
    prog[2] = 32'h6600_0064;
    prog[3] = HALT;
    start(2);
    reset = 1'b0;
    run_to_halt(n);
    chk("r6", dut.rf[6], 32'd5);
    chk("mem100", mem[100], 32'd5);
    chk("sw_hold", swc, 32'd3);
    chk("lw_hold", lwc, 32'd3);

    // BEQ r1,r1,-1 at pc 0 loops back to 0
    clear_prog();
    prog[0] = 32'h8011_FFFF;
    start(0);
    reset = 1'b0;
    repeat (12) tick;
    chk("beq_pc", {22'd0, pc_out}, 32'd0);
    chk("beq_fetches", grants, 32'd4);

    // BEQ not taken falls through to HALT at 3
    clear_prog();
    prog[0] = 32'h5100_0005;
    prog[1] = 32'h5200_FFFD;
    prog[2] = 32'h8012_0005;
    prog[3] = HALT;
    prog[8] = 32'h5700_0001;
    start(0);
    reset = 1'b0;
    run_to_halt(n);
    chk("bne_pc", {22'd0, pc_out}, 32'd3);
    chk("bne_r7", dut.rf[7], 32'd0);

    // JMP to the top word, NOP there wraps pc to 0
    clear_prog();
    prog[0] = 32'h9000_03FF;
    start(0);
    reset = 1'b0;
    repeat (4) tick;
    chk("jmp_pc", {22'd0, pc_out}, 32'h3FF);
    chk("jmp_addr", {22'd0, m.addr}, 32'h3FF);
    repeat (3) tick;
    chk("wrap_pc", {22'd0, pc_out}, 32'd0);

    // JR r1
    clear_prog();
    prog[0] = 32'h5100_0007;
    prog[1] = 32'hA010_0000;
    prog[2] = 32'h5700_0001;
    prog[3] = HALT;
    prog[7] = HALT;
    start(0);
    reset = 1'b0;
    run_to_halt(n);
    chk("jr_pc", {22'd0, pc_out}, 32'd7);
    chk("jr_r7", dut.rf[7], 32'd0);

    // Reset during a FETCH wait, stray ack after reset is ignored
    clear_prog();
    prog[0] = 32'h5100_0005;
    prog[1] = HALT;
    start(0);
    hold = 1'b1;
    reset = 1'b0;
    tick;
    tick;
    chk("wait_req", {31'd0, m.req}, 32'd1);
    reset = 1'b1;
    tick;
    chk("abort_req", {31'd0, m.req}, 32'd0);
    chk("abort_pc", {22'd0, pc_out}, 32'd0);
    reset = 1'b0;
    pulse = 1'b1;
    tick;
    pulse = 1'b0;
    hold = 1'b0;
    run_to_halt(n);
    chk("abort_r7", dut.rf[7], 32'd0);
    chk("abort_r1", dut.rf[1], 32'd5);

    // Opcode 11: MUL when enabled, NOP otherwise
    clear_prog();
    prog[0] = 32'h5100_0007;
    prog[1] = 32'h5200_FFFD;
    prog[2] = 32'h5400_0000;
    prog[3] = 32'hB312_0000;
    prog[4] = HALT;
    start(0);
    reset = 1'b0;
    run_to_halt(n);
`ifdef PROCESSOR_MC_MUL_EN
    chk("mul_r3", dut.rf[3], 32'hFFFF_FFEB);
    chk("mul_flags", {30'd0, flags}, 32'd2);
`else
    chk("mul_r3", dut.rf[3], 32'd0);
    chk("mul_flags", {30'd0, flags}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
